// File: rtl/pcileech_tlp_burst_mux.sv
// Round-robin burst multiplexer: buffers up to MAX_BURST 64-bit beats from one
// channel, then emits a header word plus the beats as low/high 32-bit halves.
//
// state     | meaning
// IDLE      | waiting for any in_valid, round-robin pick from ptr+1
// COLLECT   | accepting beats from the picked channel into the buffer
// HDR       | presenting the frame header {MAGIC, ch, cnt}
// DATA_LO   | presenting bits [31:0] of buffered beat idx
// DATA_HI   | presenting bits [63:32] of buffered beat idx
module pcileech_tlp_burst_mux #(
  parameter int          NUM_CH    = 2,
  parameter int          MAX_BURST = 16,
  parameter logic [15:0] MAGIC     = 16'h77A5
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [NUM_CH*64-1:0]   in_data,
  input  logic [NUM_CH-1:0]      in_valid,
  output logic [NUM_CH-1:0]      in_ready,
  output logic [31:0]            out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic [15:0]            burst_count
);

  localparam int AW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COLLECT = 3'd1;
  localparam logic [2:0] S_HDR     = 3'd2;
  localparam logic [2:0] S_DATA_LO = 3'd3;
  localparam logic [2:0] S_DATA_HI = 3'd4;

  logic [2:0]  state;
  logic [2:0]  ch;
  logic [2:0]  ptr;
  logic [2:0]  pick;
  logic        found;
  logic [7:0]  cnt;
  logic [7:0]  idx;
  logic        sel_valid;
  logic [63:0] sel_data;
  logic [63:0] rd_data;
  logic        wr_en;
  logic        out_fire;
  logic [63:0] burst_buf [MAX_BURST];

  // First valid channel scanning upward from ptr+1, wrapping at NUM_CH.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!found && in_valid[i] && (i == (int'(ptr) + k) % NUM_CH)) begin
          found = 1'b1;
          pick  = 3'(i);
        end
      end
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    in_ready  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch == 3'(i)) begin
        sel_valid = in_valid[i];
        sel_data  = in_data[i*64 +: 64];
      end
      in_ready[i] = (state == S_COLLECT) && (ch == 3'(i));
    end
  end

  assign wr_en     = (state == S_COLLECT) && sel_valid;
  assign out_valid = (state == S_HDR) || (state == S_DATA_LO) || (state == S_DATA_HI);
  assign out_fire  = out_valid && out_ready;
  assign busy      = (state != S_IDLE);
  assign rd_data   = burst_buf[idx[AW-1:0]];

  always_comb begin
    case (state)
      S_HDR:     out_data = {MAGIC, 1'b0, ch, 4'h0, cnt};
      S_DATA_LO: out_data = rd_data[31:0];
      S_DATA_HI: out_data = rd_data[63:32];
      default:   out_data = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= S_IDLE;
      ch          <= '0;
      ptr         <= 3'(NUM_CH - 1);
      cnt         <= '0;
      idx         <= '0;
      burst_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            ch    <= pick;
            cnt   <= '0;
            state <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (sel_valid) begin
            cnt <= cnt + 8'd1;
            if (cnt == 8'(MAX_BURST - 1)) state <= S_HDR;
          end else if (cnt == 8'd0) begin
            state <= S_IDLE;
          end else begin
            state <= S_HDR;
          end
        end
        S_HDR: begin
          if (out_fire) begin
            idx   <= '0;
            state <= S_DATA_LO;
          end
        end
        S_DATA_LO: begin
          if (out_fire) state <= S_DATA_HI;
        end
        S_DATA_HI: begin
          if (out_fire) begin
            if (idx == cnt - 8'd1) begin
              state       <= S_IDLE;
              ptr         <= ch;
              burst_count <= burst_count + 16'd1;
            end else begin
              idx   <= idx + 8'd1;
              state <= S_DATA_LO;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Buffer needs no reset: a frame only reads beats written in its own COLLECT.
  always_ff @(posedge CLK) begin
    if (wr_en) burst_buf[cnt[AW-1:0]] <= sel_data;
  end

endmodule
